// File: rtl/rename_reg_file.sv
// rtl/rename_reg_file.sv - architectural register file with rename tags and branch checkpoints
module rename_reg_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ROB_W  = 4,
  parameter int NCKPT  = 4,
  parameter int RIDX_W = $clog2(NREG),
  parameter int CK_W   = $clog2(NCKPT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              dsp_valid,
  input  logic [RIDX_W-1:0] dsp_rs1,
  input  logic [RIDX_W-1:0] dsp_rs2,
  input  logic [RIDX_W-1:0] dsp_rd,
  input  logic [ROB_W-1:0]  dsp_rob_id,
  input  logic              dsp_ckpt_req,
  output logic [CK_W-1:0]   dsp_ckpt_id,
  output logic              ckpt_full,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ROB_W-1:0]  rs1_tag,
  output logic [ROB_W-1:0]  rs2_tag,
  output logic [DATA_W-1:0] rs1_val,
  output logic [DATA_W-1:0] rs2_val,
  input  logic              cmt_valid,
  input  logic [RIDX_W-1:0] cmt_rd,
  input  logic [ROB_W-1:0]  cmt_rob_id,
  input  logic [DATA_W-1:0] cmt_data,
  input  logic              res_valid,
  input  logic [CK_W-1:0]   res_ckpt_id,
  input  logic              res_mispredict,
  input  logic              flush
);

  typedef logic [NREG-1:0][ROB_W-1:0] tag_tbl_t;

  logic [DATA_W-1:0] v_q [NREG];
  logic [NREG-1:0]   busy_q;
  tag_tbl_t          tag_q;
  logic [NREG-1:0]   ck_busy_q [NCKPT];
  tag_tbl_t          ck_tag_q  [NCKPT];
  logic [NCKPT-1:0]  ck_valid_q;
  logic [NCKPT-1:0]  ck_done_q;
  logic [CK_W-1:0]   head_q;
  logic [CK_W-1:0]   tail_q;
  logic [CK_W:0]     count_q;

  logic [NREG-1:0]   busy_n;
  tag_tbl_t          tag_n;
  logic [NCKPT-1:0]  ck_kill;
  logic [CK_W-1:0]   head_adv;
  logic [CK_W-1:0]   misp_off;

  logic do_misp, do_ok, do_dsp, do_ren, do_cmt, do_alloc, do_adv;

  assign do_misp  = res_valid && res_mispredict && !flush;
  assign do_ok    = res_valid && !res_mispredict && !flush;
  assign do_dsp   = dsp_valid && !flush && !do_misp;
  assign do_ren   = do_dsp && (dsp_rd != '0);
  assign do_cmt   = cmt_valid && (cmt_rd != '0);
  assign do_alloc = do_dsp && dsp_ckpt_req && !ckpt_full;
  assign do_adv   = ck_valid_q[head_q] && ck_done_q[head_q];
  assign head_adv = head_q + CK_W'(do_adv);
  assign misp_off = res_ckpt_id - head_q;

  assign ckpt_full   = (count_q == (CK_W+1)'(NCKPT));
  assign dsp_ckpt_id = tail_q;

  // Next live table: restore on mispredict, then commit clear, then rename (rename wins on same rd)
  always_comb begin
    busy_n = busy_q;
    tag_n  = tag_q;
    if (do_misp) begin
      busy_n = ck_busy_q[res_ckpt_id];
      tag_n  = ck_tag_q[res_ckpt_id];
    end
    if (do_cmt && (tag_n[cmt_rd] == cmt_rob_id)) busy_n[cmt_rd] = 1'b0;
    if (do_ren) begin
      busy_n[dsp_rd] = 1'b1;
      tag_n[dsp_rd]  = dsp_rob_id;
    end
    if (flush) busy_n = '0;
    busy_n[0] = 1'b0;
  end

  // Entries at or younger than the mispredicted checkpoint, measured as ring distance from head
  always_comb begin
    ck_kill = '0;
    for (int c = 0; c < NCKPT; c++) begin
      ck_kill[c] = ((CK_W'(c) - head_q) >= misp_off);
    end
  end

  // Source port 1: x0 reads zero, same-cycle commit of the current producer bypasses
  always_comb begin
    rs1_busy = busy_q[dsp_rs1];
    rs1_tag  = tag_q[dsp_rs1];
    rs1_val  = v_q[dsp_rs1];
    if (dsp_rs1 == '0) begin
      rs1_busy = 1'b0;
      rs1_val  = '0;
    end else if (cmt_valid && (cmt_rd == dsp_rs1) && busy_q[dsp_rs1] &&
                 (tag_q[dsp_rs1] == cmt_rob_id)) begin
      rs1_busy = 1'b0;
      rs1_val  = cmt_data;
    end
  end

  // Source port 2: same rules as port 1
  always_comb begin
    rs2_busy = busy_q[dsp_rs2];
    rs2_tag  = tag_q[dsp_rs2];
    rs2_val  = v_q[dsp_rs2];
    if (dsp_rs2 == '0) begin
      rs2_busy = 1'b0;
      rs2_val  = '0;
    end else if (cmt_valid && (cmt_rd == dsp_rs2) && busy_q[dsp_rs2] &&
                 (tag_q[dsp_rs2] == cmt_rob_id)) begin
      rs2_busy = 1'b0;
      rs2_val  = cmt_data;
    end
  end

  // State update: values, live table, checkpoint contents and ring pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) v_q[i] <= '0;
      busy_q <= '0;
      tag_q  <= '0;
      for (int c = 0; c < NCKPT; c++) begin
        ck_busy_q[c] <= '0;
        ck_tag_q[c]  <= '0;
      end
      ck_valid_q <= '0;
      ck_done_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (rdy) begin
      if (do_cmt) v_q[cmt_rd] <= cmt_data;
      busy_q <= busy_n;
      tag_q  <= tag_n;
      for (int c = 0; c < NCKPT; c++) begin
        if (do_cmt && (ck_tag_q[c][cmt_rd] == cmt_rob_id)) ck_busy_q[c][cmt_rd] <= 1'b0;
      end
      if (flush) begin
        ck_valid_q <= '0;
        ck_done_q  <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        if (do_adv) begin
          ck_valid_q[head_q] <= 1'b0;
          head_q             <= head_adv;
        end
        if (do_misp) begin
          for (int c = 0; c < NCKPT; c++) begin
            if (ck_kill[c]) ck_valid_q[c] <= 1'b0;
          end
          tail_q  <= res_ckpt_id;
          count_q <= {1'b0, (res_ckpt_id - head_adv)};
        end else begin
          if (do_ok) ck_done_q[res_ckpt_id] <= 1'b1;
          if (do_alloc) begin
            ck_valid_q[tail_q] <= 1'b1;
            ck_done_q[tail_q]  <= 1'b0;
            ck_busy_q[tail_q]  <= busy_n;
            ck_tag_q[tail_q]   <= tag_n;
            tail_q             <= tail_q + 1'b1;
          end
          count_q <= count_q - (CK_W+1)'(do_adv) + (CK_W+1)'(do_alloc);
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// tb/tb_rename_reg_file.sv - self-checking bench for rename_reg_file
module tb_rename_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        dsp_valid, dsp_ckpt_req;
  logic [4:0]  dsp_rs1, dsp_rs2, dsp_rd;
  logic [3:0]  dsp_rob_id;
  logic [1:0]  dsp_ckpt_id;
  logic        ckpt_full;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_tag, rs2_tag;
  logic [31:0] rs1_val, rs2_val;
  logic        cmt_valid;
  logic [4:0]  cmt_rd;
  logic [3:0]  cmt_rob_id;
  logic [31:0] cmt_data;
  logic        res_valid, res_mispredict, flush;
  logic [1:0]  res_ckpt_id;

  int checks = 0;
  int failures = 0;

  rename_reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dsp_valid(dsp_valid), .dsp_rs1(dsp_rs1), .dsp_rs2(dsp_rs2), .dsp_rd(dsp_rd),
    .dsp_rob_id(dsp_rob_id), .dsp_ckpt_req(dsp_ckpt_req), .dsp_ckpt_id(dsp_ckpt_id),
    .ckpt_full(ckpt_full),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rob_id(cmt_rob_id), .cmt_data(cmt_data),
    .res_valid(res_valid), .res_ckpt_id(res_ckpt_id), .res_mispredict(res_mispredict),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Model: live table, values, and an in-order list of live checkpoints
  typedef struct packed {
    logic [1:0]       id;
    logic             done;
    logic [31:0]      b;
    logic [31:0][3:0] t;
  } ck_t;

  logic [31:0]      mv [32];
  logic [31:0]      mb;
  logic [31:0][3:0] mt;
  ck_t              ckq [$];
  int               mtail;

  logic [31:0]      nb;
  logic [31:0][3:0] nt;
  ck_t              e;
  int               j;
  logic             misp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_port(input string name, input logic [4:0] rs, input logic busy,
                          input logic [3:0] tag, input logic [31:0] val);
    logic eb;
    logic [3:0] et;
    logic [31:0] ev;
    if (rs == 0) begin
      eb = 1'b0; et = 4'd0; ev = 32'd0;
    end else if (cmt_valid && cmt_rd == rs && mb[rs] && mt[rs] == cmt_rob_id) begin
      eb = 1'b0; et = 4'd0; ev = cmt_data;
    end else begin
      eb = mb[rs]; et = mt[rs]; ev = mv[rs];
    end
    check({name, "_busy"}, {31'd0, busy}, {31'd0, eb});
    if (eb) check({name, "_tag"}, {28'd0, tag}, {28'd0, et});
    else    check({name, "_val"}, val, ev);
  endtask

  // Model update on each active edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mv[i] = 32'd0;
      mb = '0;
      mt = '0;
      ckq.delete();
      mtail = 0;
    end else if (rdy) begin
      nb = mb;
      nt = mt;
      if (flush) begin
        nb = '0;
        ckq.delete();
        mtail = 0;
      end else begin
        if (ckq.size() > 0 && ckq[0].done) void'(ckq.pop_front());
        misp = res_valid && res_mispredict;
        if (misp) begin
          j = -1;
          for (int q = 0; q < ckq.size(); q++) if (ckq[q].id == res_ckpt_id) j = q;
          if (j >= 0) begin
            nb = ckq[j].b;
            nt = ckq[j].t;
            while (ckq.size() > j) void'(ckq.pop_back());
          end
          mtail = int'(res_ckpt_id);
        end
        if (cmt_valid && cmt_rd != 0 && nt[cmt_rd] == cmt_rob_id) nb[cmt_rd] = 1'b0;
        for (int q = 0; q < ckq.size(); q++) begin
          if (cmt_valid && cmt_rd != 0 && ckq[q].t[cmt_rd] == cmt_rob_id) begin
            e = ckq[q];
            e.b[cmt_rd] = 1'b0;
            ckq[q] = e;
          end
        end
        if (!misp) begin
          if (res_valid) begin
            for (int q = 0; q < ckq.size(); q++) begin
              if (ckq[q].id == res_ckpt_id) begin
                e = ckq[q];
                e.done = 1'b1;
                ckq[q] = e;
              end
            end
          end
          if (dsp_valid && dsp_rd != 0) begin
            nb[dsp_rd] = 1'b1;
            nt[dsp_rd] = dsp_rob_id;
          end
          if (dsp_valid && dsp_ckpt_req && ckq.size() < 4) begin
            e.id = 2'(mtail);
            e.done = 1'b0;
            e.b = nb;
            e.t = nt;
            ckq.push_back(e);
            mtail = (mtail + 1) % 4;
          end
        end
      end
      if (cmt_valid && cmt_rd != 0) mv[cmt_rd] = cmt_data;
      mb = nb;
      mt = nt;
    end
  end

  // Compare DUT outputs against the model every cycle they are meaningful
  always @(negedge clk) begin
    if (!rst && !flush && !(res_valid && res_mispredict)) begin
      chk_port("rs1", dsp_rs1, rs1_busy, rs1_tag, rs1_val);
      chk_port("rs2", dsp_rs2, rs2_busy, rs2_tag, rs2_val);
      check("ckpt_full", {31'd0, ckpt_full}, {31'd0, ckq.size() == 4});
      check("dsp_ckpt_id", {30'd0, dsp_ckpt_id}, 32'(mtail));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; dsp_valid = 1'b0; dsp_ckpt_req = 1'b0; dsp_rd = 5'd0; dsp_rob_id = 4'd0;
    dsp_rs1 = 5'd0; dsp_rs2 = 5'd0;
    cmt_valid = 1'b0; cmt_rd = 5'd0; cmt_rob_id = 4'd0; cmt_data = 32'd0;
    res_valid = 1'b0; res_ckpt_id = 2'd0; res_mispredict = 1'b0; flush = 1'b0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [3:0] tag, input logic ck);
    idle();
    dsp_valid = 1'b1; dsp_rd = rd; dsp_rob_id = tag; dsp_ckpt_req = ck;
  endtask

  task automatic cmt(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] d);
    cmt_valid = 1'b1; cmt_rd = rd; cmt_rob_id = tag; cmt_data = d;
  endtask

  task automatic res(input logic [1:0] id, input logic mp);
    res_valid = 1'b1; res_ckpt_id = id; res_mispredict = mp;
  endtask

  task automatic look(input logic [4:0] a, input logic [4:0] b);
    idle();
    dsp_rs1 = a; dsp_rs2 = b;
    #2;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    look(5'd5, 5'd0);
    check("lit_reset_x5_busy", {31'd0, rs1_busy}, 32'd0);
    check("lit_reset_x5_val", rs1_val, 32'd0);
    check("lit_reset_x0_val", rs2_val, 32'd0);
    check("lit_reset_full", {31'd0, ckpt_full}, 32'd0);
    check("lit_reset_ckid", {30'd0, dsp_ckpt_id}, 32'd0);

    idle(); cmt(5'd5, 4'd3, 32'hDEAD); tick();
    look(5'd5, 5'd0);
    check("lit_x5_val", rs1_val, 32'hDEAD);

    ren(5'd7, 4'd2, 1'b0); tick();
    look(5'd7, 5'd5);
    check("lit_x7_busy", {31'd0, rs1_busy}, 32'd1);
    check("lit_x7_tag", {28'd0, rs1_tag}, 32'd2);
    cmt(5'd7, 4'd2, 32'h11); #1;
    check("lit_x7_bypass_busy", {31'd0, rs1_busy}, 32'd0);
    check("lit_x7_bypass_val", rs1_val, 32'h11);
    tick();
    look(5'd7, 5'd0);
    check("lit_x7_after_val", rs1_val, 32'h11);

    ren(5'd7, 4'd2, 1'b0); tick();
    ren(5'd7, 4'd5, 1'b0); tick();
    idle(); cmt(5'd7, 4'd2, 32'h22); tick();
    look(5'd7, 5'd0);
    check("lit_x7_still_busy", {31'd0, rs1_busy}, 32'd1);
    check("lit_x7_young_tag", {28'd0, rs1_tag}, 32'd5);

    ren(5'd3, 4'd1, 1'b0); tick();
    ren(5'd0, 4'd0, 1'b1); #1;
    check("lit_branch_ckid", {30'd0, dsp_ckpt_id}, 32'd0);
    tick();
    ren(5'd3, 4'd4, 1'b0); tick();
    ren(5'd8, 4'd6, 1'b0); tick();
    idle(); res(2'd0, 1'b1); tick();
    look(5'd3, 5'd8);
    check("lit_restore_x3_busy", {31'd0, rs1_busy}, 32'd1);
    check("lit_restore_x3_tag", {28'd0, rs1_tag}, 32'd1);
    check("lit_restore_x8_busy", {31'd0, rs2_busy}, 32'd0);
    check("lit_restore_ckid", {30'd0, dsp_ckpt_id}, 32'd0);

    ren(5'd3, 4'd1, 1'b0); tick();
    ren(5'd0, 4'd0, 1'b1); tick();
    ren(5'd3, 4'd4, 1'b0); tick();
    idle(); res(2'd0, 1'b1); cmt(5'd3, 4'd1, 32'h33); tick();
    look(5'd3, 5'd7);
    check("lit_restore_cmt_busy", {31'd0, rs1_busy}, 32'd0);
    check("lit_restore_cmt_val", rs1_val, 32'h33);

    for (int k = 0; k < 4; k++) begin
      ren(5'd9, 4'(k + 8), 1'b1); #1;
      check("lit_alloc_ckid", {30'd0, dsp_ckpt_id}, 32'(k));
      tick();
    end
    look(5'd9, 5'd3);
    check("lit_full", {31'd0, ckpt_full}, 32'd1);
    idle(); res(2'd2, 1'b0); tick();
    idle(); tick(); tick();
    look(5'd9, 5'd0);
    check("lit_full_after_ooo", {31'd0, ckpt_full}, 32'd1);
    idle(); res(2'd0, 1'b0); tick();
    idle(); res(2'd1, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin idle(); tick(); end
    look(5'd9, 5'd0);
    check("lit_drain_full", {31'd0, ckpt_full}, 32'd0);
    check("lit_drain_ckid", {30'd0, dsp_ckpt_id}, 32'd0);
    for (int k = 0; k < 3; k++) begin ren(5'd10, 4'(k + 1), 1'b1); tick(); end
    look(5'd10, 5'd9);
    check("lit_refill_full", {31'd0, ckpt_full}, 32'd1);

    idle(); ren(5'd11, 4'd7, 1'b1); tick();
    res(2'd1, 1'b1); cmt(5'd10, 4'd1, 32'h44); tick();
    look(5'd10, 5'd11);
    idle(); flush = 1'b1; tick();
    look(5'd9, 5'd7);
    check("lit_flush_full", {31'd0, ckpt_full}, 32'd0);
    check("lit_flush_x9_busy", {31'd0, rs1_busy}, 32'd0);
    check("lit_flush_x7_busy", {31'd0, rs2_busy}, 32'd0);

    idle(); rdy = 1'b0; dsp_valid = 1'b1; dsp_rd = 5'd12; dsp_rob_id = 4'd7;
    cmt(5'd5, 4'd3, 32'hBEEF); tick();
    look(5'd12, 5'd5);
    check("lit_frozen_x12_busy", {31'd0, rs1_busy}, 32'd0);
    check("lit_frozen_x5_val", rs2_val, 32'hDEAD);

    idle(); tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
